hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Drives the stall/flush side of the ID/EX pipeline register, plus PC and IF/ID enables.
//  Detects load-use hazards against the instruction in ID/EX and sequences taken-branch flushes.
//  Freezes the pipe while data memory is busy and keeps saturating hazard event counters.
//  Sits in the ID stage beside the register file. Fed by IF/ID fields, ID/EX outputs and MEM-stage branch resolution.
// PARAMETERS
//  BR_PENALTY  2   cycles flush stays asserted per taken branch (1..7)
//  CNT_W       16  width of each event counter
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-low
//  if_id_rs       in   5      rs field of instruction in ID
//  if_id_rt       in   5      rt field of instruction in ID
//  id_uses_rt     in   1      ID instruction reads rt as a source (R-type, store, beq)
//  id_ex_memRead  in   1      load currently in EX
//  id_ex_rt       in   5      destination rt of the EX-stage load
//  branch_taken   in   1      one-cycle pulse: branch resolved taken in MEM
//  dmem_busy      in   1      data memory wait-state request
//  pc_write       out  1      PC register enable
//  if_id_write    out  1      IF/ID register enable
//  if_id_flush    out  1      zero IF/ID
//  id_ex_stall    out  1      insert bubble into ID/EX (load-use)
//  id_ex_flush    out  1      zero ID/EX (branch)
//  ex_mem_flush   out  1      zero EX/MEM (branch)
//  pipe_freeze    out  1      hold all enable-capable pipe registers
//  hazard_state   out  2      current FSM state
//  stall_count    out  CNT_W  load-use bubbles inserted (saturating)
//  flush_count    out  CNT_W  taken-branch flush events (saturating)
//  freeze_count   out  CNT_W  frozen cycles (saturating)
// BEHAVIOUR
//  Reset (async low): state=RUN, flush_left=0, br_pending=0, all counters=0.
//   While reset is low: pc_write=if_id_write=0, every flush/stall/freeze output=0.
//  Control outputs are Mealy (same-cycle). State and counters update on the rising clk edge.
//  Load-use hit (lu):
//   id_ex_memRead && id_ex_rt!=0 && (id_ex_rt==if_id_rs || (id_uses_rt && id_ex_rt==if_id_rt)).
//  States: RUN=0, FLUSH=1, FREEZE=2 (3 unused, decodes to RUN).
//  Priority each cycle: freeze > branch flush > load-use. Lower-priority events are masked.
//  RUN:
//   - dmem_busy: pipe_freeze=1, pc_write=if_id_write=0, no flush/stall.
//     If branch_taken also asserted, set br_pending=1. Next state -> FREEZE.
//   - else branch_taken (or br_pending): if_id_flush=id_ex_flush=ex_mem_flush=1,
//     pc_write=if_id_write=1 (target loads), br_pending<=0, flush_count++.
//     If BR_PENALTY>1: flush_left<=BR_PENALTY-1, -> FLUSH; else stay RUN.
//   - else lu: pc_write=if_id_write=0, id_ex_stall=1 for exactly this cycle, stall_count++.
//     The bubble clears id_ex_memRead, so a second stall cycle cannot occur for the same load.
//   - else: pc_write=if_id_write=1, all flush/stall=0.
//  FLUSH: three flush outputs=1, pc_write=if_id_write=1, lu masked.
//   flush_left-- each cycle; at 1 -> RUN.
//   A new branch_taken in FLUSH reloads flush_left=BR_PENALTY-1 and counts a new flush event.
//   dmem_busy in FLUSH: freeze wins. flush_left holds, -> FREEZE; resumes FLUSH on release.
//  FREEZE: pipe_freeze=1, pc_write=if_id_write=0, freeze_count++ each cycle.
//   branch_taken sets br_pending.
//   On !dmem_busy: -> FLUSH if flush_left!=0, else RUN. br_pending is serviced in that cycle as in RUN.
//   That cycle itself is not frozen.
//  Counters saturate at all-ones; no wrap.
//  Reset mid-FLUSH or mid-FREEZE abandons the sequence; pending branch is discarded.
// STRUCTURE
//  hazard_pkg: state localparams (HZ_RUN/HZ_FLUSH/HZ_FREEZE), REG_ZERO=5'd0, default CNT_W.
//  Sub-module hazard_sat_counter (params W; ports clk, reset, inc, count), instantiated x3.
//  FSM, lu compare and output decode live in hazard_ctrl_unit.
// TESTING
//  1. memRead=1,id_ex_rt=8,if_id_rs=8 -> one cycle pc_write=0,id_ex_stall=1; next cycle (memRead=0) pc_write=1; stall_count=1.
//  2. memRead=1,id_ex_rt=0,if_id_rs=0 -> no stall. id_ex_rt=9,if_id_rt=9,id_uses_rt=0 -> no stall.
//  3. BR_PENALTY=2: branch_taken pulse -> flushes high exactly 2 cycles, state RUN->FLUSH->RUN, flush_count=1.
//  4. dmem_busy 3 cycles with branch_taken in cycle 2 -> freeze 3 cycles, flush starts the release cycle; freeze_count=3.
//  5. branch_taken and lu in same cycle -> flushes=1, id_ex_stall=0, pc_write=1; stall_count unchanged.
//  6. CNT_W=4: 20 load-use events -> stall_count=15. Reset low mid-FLUSH -> outputs 0, counters 0, state RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : hazard_pkg
//  Description : Shared constants for the ID-stage hazard control unit:
//                FSM state encodings, the hard-wired zero register index and
//                the default event-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // FSM state encodings; code 2'd3 is unused and decodes as RUN.
  localparam logic [1:0] HZ_RUN    = 2'd0;
  localparam logic [1:0] HZ_FLUSH  = 2'd1;
  localparam logic [1:0] HZ_FREEZE = 2'd2;

  // Register $zero never carries a real dependency.
  localparam logic [4:0] REG_ZERO  = 5'd0;

  // Default width of each saturating event counter.
  localparam int HZ_CNT_W = 16;

  // Width of the remaining-flush-cycles counter (covers penalties 1..7).
  localparam int HZ_FLW = 3;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sat_counter
//  Description : Up-counter that increments on i_inc and sticks at all-ones
//                instead of wrapping. Cleared by the asynchronous low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] c_ONE = W'(1);
  localparam logic [W-1:0] c_MAX = '1;

  logic [W-1:0] r_count;

  // Count events, holding at the maximum value once reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != c_MAX)) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign o_count = r_count;

endmodule : hazard_sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_unit
//  Description : ID-stage hazard controller. Detects load-use hazards against
//                the load in ID/EX, sequences multi-cycle taken-branch
//                flushes, freezes the pipe while data memory is busy and keeps
//                saturating counters of stall, flush and freeze events.
//                Control outputs are Mealy; priority is
//                freeze > branch flush > load-use.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = HZ_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       i_if_id_rs,
  input  logic [4:0]       i_if_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_id_ex_memRead,
  input  logic [4:0]       i_id_ex_rt,
  input  logic             i_branch_taken,
  input  logic             i_dmem_busy,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_stall,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_flush,
  output logic             o_pipe_freeze,
  output logic [1:0]       o_hazard_state,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count,
  output logic [CNT_W-1:0] o_freeze_count
);

  // Flush cycles still owed after the cycle in which the branch is taken.
  localparam logic [HZ_FLW-1:0] c_FL_RELOAD = HZ_FLW'(BR_PENALTY - 1);
  localparam logic [HZ_FLW-1:0] c_FL_ONE    = HZ_FLW'(1);
  localparam logic [HZ_FLW-1:0] c_FL_ZERO   = '0;
  // A one-cycle penalty is fully covered by the branch cycle itself.
  localparam logic              c_MULTI     = (BR_PENALTY > 1);

  logic [1:0]        r_state;
  logic [HZ_FLW-1:0] r_flush_left;
  logic              r_br_pending;

  logic [1:0]        w_state_nxt;
  logic [HZ_FLW-1:0] w_flush_left_nxt;
  logic              w_br_pending_nxt;

  logic w_lu;
  logic w_br;
  logic w_flush_mode;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_flush;
  logic w_stall;
  logic w_freeze;
  logic w_stall_inc;
  logic w_flush_inc;

  // Load-use hit: the EX-stage load writes a register the ID instruction reads.
  always_comb begin
    w_lu = i_id_ex_memRead && (i_id_ex_rt != REG_ZERO) &&
           ((i_id_ex_rt == i_if_id_rs) ||
            (i_id_uses_rt && (i_id_ex_rt == i_if_id_rt)));
  end

  // Control decode and next-state logic, evaluated in priority order.
  always_comb begin
    w_pc_write       = 1'b0;
    w_if_id_write    = 1'b0;
    w_flush          = 1'b0;
    w_stall          = 1'b0;
    w_freeze         = 1'b0;
    w_stall_inc      = 1'b0;
    w_flush_inc      = 1'b0;
    w_state_nxt      = r_state;
    w_flush_left_nxt = r_flush_left;
    w_br_pending_nxt = r_br_pending;

    // A branch remembered across a freeze is serviced like a fresh one.
    w_br = i_branch_taken || r_br_pending;

    // Leaving FREEZE resumes an interrupted flush sequence in the same cycle.
    case (r_state)
      HZ_FLUSH:  w_flush_mode = 1'b1;
      HZ_FREEZE: w_flush_mode = (r_flush_left != c_FL_ZERO);
      default:   w_flush_mode = 1'b0;
    endcase

    if (i_dmem_busy) begin
      // Memory wait state: hold everything, remember any branch for later.
      w_freeze         = 1'b1;
      w_br_pending_nxt = r_br_pending | i_branch_taken;
      w_state_nxt      = HZ_FREEZE;
    end else if (w_flush_mode) begin
      w_flush       = 1'b1;
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
      if (w_br) begin
        // A new taken branch restarts the penalty window.
        w_flush_inc      = 1'b1;
        w_br_pending_nxt = 1'b0;
        w_flush_left_nxt = c_FL_RELOAD;
        w_state_nxt      = c_MULTI ? HZ_FLUSH : HZ_RUN;
      end else begin
        w_flush_left_nxt = r_flush_left - c_FL_ONE;
        w_state_nxt      = (r_flush_left == c_FL_ONE) ? HZ_RUN : HZ_FLUSH;
      end
    end else if (w_br) begin
      w_flush          = 1'b1;
      w_pc_write       = 1'b1;
      w_if_id_write    = 1'b1;
      w_flush_inc      = 1'b1;
      w_br_pending_nxt = 1'b0;
      if (c_MULTI) begin
        w_flush_left_nxt = c_FL_RELOAD;
        w_state_nxt      = HZ_FLUSH;
      end else begin
        w_state_nxt      = HZ_RUN;
      end
    end else if (w_lu) begin
      // Single bubble: the bubble itself clears memRead in ID/EX next cycle.
      w_stall     = 1'b1;
      w_stall_inc = 1'b1;
      w_state_nxt = HZ_RUN;
    end else begin
      w_pc_write    = 1'b1;
      w_if_id_write = 1'b1;
      w_state_nxt   = HZ_RUN;
    end
  end

  // FSM state, remaining flush cycles and pending-branch flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= HZ_RUN;
      r_flush_left <= '0;
      r_br_pending <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_left <= w_flush_left_nxt;
      r_br_pending <= w_br_pending_nxt;
    end
  end

  // Force every control output low while reset is held.
  always_comb begin
    o_pc_write     = reset & w_pc_write;
    o_if_id_write  = reset & w_if_id_write;
    o_if_id_flush  = reset & w_flush;
    o_id_ex_stall  = reset & w_stall;
    o_id_ex_flush  = reset & w_flush;
    o_ex_mem_flush = reset & w_flush;
    o_pipe_freeze  = reset & w_freeze;
    o_hazard_state = r_state;
  end

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_stall_inc),
    .o_count (o_stall_count)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_flush_inc),
    .o_count (o_flush_count)
  );

  hazard_sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_freeze),
    .o_count (o_freeze_count)
  );

endmodule : hazard_ctrl_unit
`default_nettype wire
